// File: rtl/ext_responder_pkg.sv
// Shared types and sizing helpers for the external-block responder.
// Response entries carry a fixed-width data field; narrower stores zero-extend into it.
package ext_responder_pkg;

    localparam int RESP_DATA_MAX = 64;

    typedef struct packed {
        logic                     is_wr;
        logic [RESP_DATA_MAX-1:0] rdata;
    } resp_t;

    // Number of byte-offset bits dropped from a byte address to reach a word address.
    function automatic int byte_off_width(input int data_width);
        return (data_width <= 8) ? 0 : $clog2(data_width / 8);
    endfunction

    // Width of the word index into the backing store (at least one bit).
    function automatic int word_idx_width(input int n_words);
        return (n_words <= 2) ? 1 : $clog2(n_words);
    endfunction

endpackage

// File: rtl/ext_resp_fifo.sv
// Synchronous response FIFO with asynchronous reset on its pointers and occupancy.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module ext_resp_fifo
    import ext_responder_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  resp_t                push_data,
    input  logic                 pop,
    output resp_t                head,
    output logic                 full,
    output logic                 empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    resp_t          store [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = store[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Payload storage needs no reset: entries are only read once count says they are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            store[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/ext_block_responder.sv
// Bench-side responder for a regblock external-block port: word store, fixed-latency
// delay line, throttleable in-order response FIFO with same-cycle bypass when idle.
module ext_block_responder
    import ext_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int N_WORDS    = 16,
    parameter int LATENCY    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  req,
    input  logic [ADDR_WIDTH-1:0]                 addr,
    input  logic                                  req_is_wr,
    input  logic [DATA_WIDTH-1:0]                 wr_data,
    input  logic [DATA_WIDTH-1:0]                 wr_biten,
    input  logic                                  hold,
    output logic                                  rd_ack,
    output logic [DATA_WIDTH-1:0]                 rd_data,
    output logic                                  wr_ack,
    output logic [$clog2(FIFO_DEPTH+LATENCY):0]   pending,
    output logic                                  overflow
);

    localparam int OFF_W = byte_off_width(DATA_WIDTH);
    localparam int IDX_W = word_idx_width(N_WORDS);
    localparam int PW    = $clog2(FIFO_DEPTH + LATENCY) + 1;

    logic [DATA_WIDTH-1:0] mem [N_WORDS];
    logic [IDX_W-1:0]      word_idx;

    logic [LATENCY-1:0]    dl_valid;
    logic [LATENCY-1:0]    dl_is_wr;
    logic [DATA_WIDTH-1:0] dl_rdata [LATENCY];

    resp_t                 emit_entry;
    logic                  emit_valid;
    resp_t                 fifo_head;
    resp_t                 ack_entry;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  bypass;
    logic                  drop;
    logic                  ack_now;
    logic                  unused_bits;

    // Modulo N_WORDS falls out of keeping only the low index bits of the word address.
    assign word_idx = addr[OFF_W +: IDX_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (req && req_is_wr) begin
            mem[word_idx] <= (mem[word_idx] & ~wr_biten) | (wr_data & wr_biten);
        end
    end

    // Read data is sampled from mem before any same-edge update lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dl_valid <= '0;
            dl_is_wr <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                dl_rdata[i] <= '0;
            end
        end else begin
            dl_valid[0] <= req;
            dl_is_wr[0] <= req && req_is_wr;
            dl_rdata[0] <= (req && !req_is_wr) ? mem[word_idx] : '0;
            for (int i = 1; i < LATENCY; i++) begin
                dl_valid[i] <= dl_valid[i-1];
                dl_is_wr[i] <= dl_is_wr[i-1];
                dl_rdata[i] <= dl_rdata[i-1];
            end
        end
    end

    assign emit_valid = dl_valid[LATENCY-1];

    always_comb begin
        emit_entry                         = '0;
        emit_entry.is_wr                   = dl_is_wr[LATENCY-1];
        emit_entry.rdata[DATA_WIDTH-1:0]   = dl_rdata[LATENCY-1];
    end

    // Bypass only when nothing older is queued, so ordering is preserved.
    assign fifo_pop  = !hold && !fifo_empty;
    assign bypass    = emit_valid && fifo_empty && !hold;
    assign fifo_push = emit_valid && !bypass && (!fifo_full || fifo_pop);
    assign drop      = emit_valid && !bypass && fifo_full && !fifo_pop;
    assign ack_now   = fifo_pop || bypass;
    assign ack_entry = fifo_pop ? fifo_head : emit_entry;

    ext_resp_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (emit_entry),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ack   <= 1'b0;
            wr_ack   <= 1'b0;
            rd_data  <= '0;
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            rd_ack   <= ack_now && !ack_entry.is_wr;
            wr_ack   <= ack_now && ack_entry.is_wr;
            rd_data  <= (ack_now && !ack_entry.is_wr) ? ack_entry.rdata[DATA_WIDTH-1:0] : '0;
            pending  <= pending + PW'(req) - PW'(ack_now) - PW'(drop);
            overflow <= overflow || drop;
        end
    end

    assign unused_bits = ^{addr, ack_entry.rdata, fifo_count};

endmodule
